baugh_wooley_mult_4bit: RTL and testbench
=========================================

// Module: baugh_wooley_mult_4bit
// PURPOSE
//  Signed 4x4 two's-complement multiplier built as a Baugh-Wooley carry-save array.
//  Produces an 8-bit signed product.
//  The product is registered once, so the block drops into a clocked datapath with fixed 1-cycle latency.
//  Leaf arithmetic unit; no memory, no flow control beyond a valid bit.
// PARAMETERS
//  N  4  operand width in bits; fixed at 4 for this block (product width 2*N = 8)
// PORTS
//  clk       input   1  single clock; all state updates on rising edge
//  rst       input   1  synchronous, active-high reset
//  in_valid  input   1  A/B valid this cycle
//  A         input   4  multiplicand, signed two's complement (-8..7)
//  B         input   4  multiplier, signed two's complement (-8..7)
//  out_valid output  1  AB holds product of operands sampled on previous edge with in_valid=1
//  AB        output  8  signed product A*B (-56..64)
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge forces AB=8'h00 and out_valid=0. Reset dominates in_valid on the same edge.
//  - Latency: 1 cycle. On each edge with rst=0:
//    - out_valid <= in_valid
//    - AB <= A*B (signed) when in_valid=1; AB holds its value when in_valid=0.
//  - Throughput: one product per cycle. Back-to-back in_valid is allowed; no stall or backpressure.
//  - Arithmetic: the result is exact for every pair in -8..7 x -8..7; no overflow is possible.
//    - Extremes: -8*-8 = +64 (8'h40); -8*7 = -56 (8'hC8).
//  - Baugh-Wooley rules, i,j = 0..3, pp(i,j) = A[i]&B[j]:
//    - pp(i,j) is complemented when exactly one of i, j equals 3.
//    - pp(3,3) is uncomplemented.
//    - Constant 1 is added at weight 2^4 and at weight 2^7.
//    - Carry out of bit 7 is discarded.
//  - The combinational array sits before the output register. No X-propagation beyond unknown inputs.
//  - rst asserted mid-stream discards any in-flight product. out_valid is 0 on the cycle after reset.
// STRUCTURE
//  - Shared package mult_pkg:
//    - localparam MULT_N = 4; localparam MULT_PW = 2*MULT_N
//    - typedefs operand_t = logic signed [MULT_N-1:0] and product_t = logic signed [MULT_PW-1:0]
//  - Sub-module full_adder (a, b, cin -> sum, cout), instantiated across the array.
//    - 4-row carry-save array, then a ripple final row.
//    - Half adders may be realised as full_adder with cin=0.
//  - Partial-product generation and complement selection in a generate loop.
//  - A single always block for the output/valid register.
// TESTING
//  Compare AB against $signed(A)*$signed(B) one cycle after every in_valid=1.
//  1. Reset: rst=1 for 2 cycles with in_valid=1, A=3, B=7 -> AB=0, out_valid=0 throughout.
//  2. Directed products, back-to-back, one per cycle -> each AB one cycle later:
//     - 3*7=21 (8'h15); -2*8(=-8)=16 (8'h10); -3*5=-15 (8'hF1)
//     - -3*-7=21; -7*8(=-8)=56 (8'h38); 0*-1=0; -7*7=-49 (8'hCF)
//  3. Extremes: -8*-8 -> 64 (8'h40); -8*7 -> -56 (8'hC8); 7*7 -> 49 (8'h31).
//  4. Hold: in_valid=1 with A=5, B=-2, then in_valid=0 with A,B changing
//     -> AB stays -10 (8'hF6), out_valid 1 then 0.
//  5. Reset mid-stream: in_valid=1 with A=6, B=3, then rst=1 on the next edge -> AB=0, out_valid=0.
//     After release, the next product is correct.
//  6. Exhaustive sweep of all 256 operand pairs, streamed at 1 per cycle -> zero mismatches.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared widths and operand/product types for the Baugh-Wooley multiplier.
package mult_pkg;
   localparam int MULT_N  = 4;
   localparam int MULT_PW = 2 * MULT_N;

   typedef logic signed [MULT_N-1:0]  operand_t;
   typedef logic signed [MULT_PW-1:0] product_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of the multiplier array.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/baugh_wooley_mult_4bit.sv
// Signed 4x4 Baugh-Wooley carry-save multiplier with a registered 8-bit product.
module baugh_wooley_mult_4bit
   import mult_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [MULT_N-1:0]    A,
   input  logic [MULT_N-1:0]    B,
   output logic                 out_valid,
   output logic [MULT_PW-1:0]   AB
);
   logic [MULT_N-1:0][MULT_PW-1:0] row_w;
   logic [MULT_N:0][MULT_PW-1:0]   sv;
   logic [MULT_N:0][MULT_PW-1:0]   cv;
   logic [MULT_N-1:0][MULT_PW-2:0] co;
   logic [MULT_PW-1:0]             rc;
   product_t                       prod;

   // Row j carries pp(i,j) at weight i+j; sign-row/column terms are inverted.
   for (genvar j = 0; j < MULT_N; j++) begin : g_row
      for (genvar k = 0; k < MULT_PW; k++) begin : g_bit
         if (k >= j && k < j + MULT_N) begin : g_pp
            localparam int I = k - j;
            if ((I == MULT_N-1) != (j == MULT_N-1)) begin : g_inv
               assign row_w[j][k] = ~(A[I] & B[j]);
            end else begin : g_pos
               assign row_w[j][k] = A[I] & B[j];
            end
         end else begin : g_zero
            assign row_w[j][k] = 1'b0;
         end
      end
   end

   // The two correction ones (weights 2^4 and 2^7) seed the carry vector.
   assign sv[0] = '0;
   assign cv[0] = 8'b1001_0000;

   for (genvar r = 0; r < MULT_N; r++) begin : g_csa
      for (genvar k = 0; k < MULT_PW - 1; k++) begin : g_fa
         full_adder u_fa (
            .a    (sv[r][k]),
            .b    (cv[r][k]),
            .cin  (row_w[r][k]),
            .sum  (sv[r+1][k]),
            .cout (co[r][k])
         );
      end
      assign sv[r+1][MULT_PW-1] = sv[r][MULT_PW-1] ^ cv[r][MULT_PW-1] ^ row_w[r][MULT_PW-1];
      assign cv[r+1]            = {co[r], 1'b0};
   end

   // Final ripple row; the carry out of the top bit is dropped.
   assign rc[0] = 1'b0;
   for (genvar k = 0; k < MULT_PW - 1; k++) begin : g_rip
      full_adder u_fa (
         .a    (sv[MULT_N][k]),
         .b    (cv[MULT_N][k]),
         .cin  (rc[k]),
         .sum  (prod[k]),
         .cout (rc[k+1])
      );
   end
   assign prod[MULT_PW-1] = sv[MULT_N][MULT_PW-1] ^ cv[MULT_N][MULT_PW-1] ^ rc[MULT_PW-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         AB        <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            AB <= prod;
         end
      end
   end
endmodule

// File: tb/tb_baugh_wooley_mult_4bit.sv
// Scoreboard bench for baugh_wooley_mult_4bit: expected products queue up as operands are driven.
module tb_baugh_wooley_mult_4bit;
   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] A;
   logic [3:0] B;
   logic       out_valid;
   logic [7:0] AB;

   logic [7:0] exp_q[$];
   logic [7:0] held_ab;
   int         n_checks;
   int         n_passed;

   baugh_wooley_mult_4bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .AB        (AB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_checks++;
      if (observed === expected) begin
         n_passed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h (A=%0d B=%0d)", tag, observed, expected,
                  $signed(A), $signed(B));
      end
   endtask

   // Drive one cycle of inputs, then check what the DUT shows just after the edge.
   task automatic apply_stimulus(input logic v, input int a, input int b, input logic r);
      logic signed [3:0] a4;
      logic signed [3:0] b4;
      int                p;
      a4       = 4'(a);
      b4       = 4'(b);
      rst      = r;
      in_valid = v;
      A        = a4;
      B        = b4;
      if (!r && v) begin
         p = int'(a4) * int'(b4);
         exp_q.push_back(p[7:0]);
      end
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         held_ab = 8'h00;
         check_output("rst_ab", AB, 8'h00);
         check_output("rst_valid", {7'b0, out_valid}, 8'h00);
      end else if (exp_q.size() > 0) begin
         held_ab = exp_q.pop_front();
         check_output("valid_hi", {7'b0, out_valid}, 8'h01);
         check_output("product", AB, held_ab);
      end else begin
         check_output("valid_lo", {7'b0, out_valid}, 8'h00);
         check_output("hold", AB, held_ab);
      end
   endtask

   int dir_a[7] = '{3, -2, -3, -3, -7, 0, -7};
   int dir_b[7] = '{7, 8, 5, -7, 8, -1, 7};

   initial begin
      n_checks = 0;
      n_passed = 0;
      held_ab  = 8'h00;
      rst      = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;

      apply_stimulus(1'b1, 3, 7, 1'b1);
      apply_stimulus(1'b1, 3, 7, 1'b1);

      for (int i = 0; i < 7; i++) apply_stimulus(1'b1, dir_a[i], dir_b[i], 1'b0);

      apply_stimulus(1'b1, -8, -8, 1'b0);
      check_output("ext_m8m8", AB, 8'h40);
      apply_stimulus(1'b1, -8, 7, 1'b0);
      check_output("ext_m8p7", AB, 8'hC8);
      apply_stimulus(1'b1, 7, 7, 1'b0);
      check_output("ext_p7p7", AB, 8'h31);

      apply_stimulus(1'b1, 5, -2, 1'b0);
      check_output("hold_src", AB, 8'hF6);
      apply_stimulus(1'b0, 1, 2, 1'b0);
      apply_stimulus(1'b0, -3, 4, 1'b0);
      check_output("hold_kept", AB, 8'hF6);

      apply_stimulus(1'b1, 6, 3, 1'b0);
      apply_stimulus(1'b1, 2, 2, 1'b1);
      apply_stimulus(1'b1, -4, 3, 1'b0);
      check_output("post_rst", AB, 8'hF4);

      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            apply_stimulus(1'b1, ia, ib, 1'b0);
         end
      end
      apply_stimulus(1'b0, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end
endmodule
